lcg_seed_scan: RTL and testbench
================================

// Module: lcg_seed_scan
// PURPOSE
//  Brute-force recovery of an LCG seed from NUM_OBS consecutive observed outputs.
//  Scans an inclusive seed range with LANES candidates per batch.
//  Reports the lowest matching seed, or exhaustion, through a start/done handshake.
//  Top-level use: constants from config registers, done/found drive the board LED.
// PARAMETERS
//  WIDTH    32  state/operand width (bits)
//  NUM_OBS  3   consecutive observed outputs compared (>=1)
//  LANES    4   candidate seeds evaluated in parallel per batch (>=1)
// PORTS
//  CLK          in   1               system clock
//  RST_N        in   1               asynchronous active-low reset
//  start        in   1               one-cycle request; sampled only in IDLE
//  abort        in   1               cancel scan; ends with found=0
//  seed_lo      in   WIDTH           first candidate seed (inclusive)
//  seed_hi      in   WIDTH           last candidate seed (inclusive)
//  multiplier   in   WIDTH           a
//  increment    in   WIDTH           c
//  modulus      in   WIDTH           m; used only with LCG_MODULUS_EN
//  obs_data     in   NUM_OBS*WIDTH   expected v0 in [WIDTH-1:0], v1 in next slice, ...
//  busy         out  1               high from accepted start until done
//  done         out  1               one-cycle pulse at scan end
//  found        out  1               valid with done, held until next start
//  valid_seed   out  WIDTH           lowest matching seed; held with found
//  seeds_tried  out  WIDTH+1         candidates evaluated so far; held after done
// BEHAVIOUR
//  Reset: all outputs 0; FSM in IDLE.
//  Latch: on start in IDLE, latch every input; inputs may then change freely.
//  Ignored: start while busy.
//  Chain: v0 = step(seed), v(k) = step(v(k-1)); step(x) = (a*x + c) mod M.
//   M = 2^WIDTH by default (natural truncation).
//  FSM: IDLE -> LOAD -> STEP(k=0..NUM_OBS-1) -> CHECK -> LOAD | FIN -> IDLE.
//   LOAD: lane i gets seed base+i; lanes with base+i > seed_hi are masked.
//    base is kept in WIDTH+1 bits, so no wrap at 2^WIDTH-1.
//   STEP k: all lanes advance one step.
//    A lane whose v(k) != obs(k) is killed (sticky for the batch).
//    STEP k takes STEP_LAT cycles.
//   CHECK (1 cycle): any live unmasked lane -> valid_seed = lowest-index live seed,
//    found=1, go to FIN.
//    Otherwise seeds_tried += unmasked lane count.
//    Then, if base+LANES > seed_hi -> FIN with found=0; else base += LANES, go to LOAD.
//   FIN: done=1 for 1 cycle, busy falls the same cycle, then IDLE.
//  Batch latency: 1 + NUM_OBS*STEP_LAT + 1 cycles.
//  Empty range (seed_hi < seed_lo): LOAD -> FIN directly; found=0, seeds_tried=0.
//  Full range (seed_lo=0, seed_hi=2^WIDTH-1): terminates; seeds_tried = 2^WIDTH.
//  abort: any non-IDLE state -> FIN next cycle; found=0; seeds_tried keeps count.
//  abort in the same cycle as CHECK success: success wins.
//  Width rules: product is 2*WIDTH bits; the reduction operates on the full product.
//  Reset mid-scan: immediate return to IDLE, all outputs 0.
// CONFIGURATION
//  LCG_MODULUS_EN undefined: M = 2^WIDTH; STEP_LAT = 1; modulus port unused.
//  LCG_MODULUS_EN defined: M = modulus, reduced by shift-subtract of the 2W-bit sum;
//   STEP_LAT = 2*WIDTH+1.
//   Inputs require a, c, seeds and obs < m.
//   modulus=0 at start -> FIN immediately with found=0.
// STRUCTURE
//  Package lcg_pkg: FSM state enum; STEP_LAT function of WIDTH and the macro;
//   obs slice helper.
//  Sub-module lcg_step (LANES instances): start/ready handshake.
//   Output is (a*x+c) mod M after STEP_LAT cycles.
//  Top level owns the FSM, base, the kill mask, the priority encoder and seeds_tried.
// TESTING
//  T1 wrap mode: a=4001, c=60211, obs={444307,1777732518,242022553}, range 0..200
//   -> found=1, valid_seed=96, done within 25 batches.
//  T2 LCG_MODULUS_EN: m=993441, same a/c, obs={444307,466569,127141}, range 0..200
//   -> found=1, valid_seed=96.
//  T3 range 0..95 with T1 data -> done, found=0, seeds_tried=96.
//   Then range 97..97 -> found=0, seeds_tried=1.
//  T4 LANES=4, obs chosen so seeds 97 and 98 both match (a=0, c=5, obs all 5)
//   -> valid_seed = seed_lo = lowest; seed_lo=97 -> 97.
//  T5 seed_hi < seed_lo -> done within 3 cycles, found=0.
//   Extra start pulses while busy are ignored.
//  T6 abort mid-scan -> done next cycle, found=0.
//   Also: RST_N low mid-scan -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/lcg_pkg.sv
// Shared definitions for the LCG seed scanner.
// Build option: LCG_MODULUS_EN selects the programmable-modulus step datapath.
package lcg_pkg;

  // Scanner FSM states
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STEP,
    S_CHECK,
    S_FIN
  } state_t;

`ifdef LCG_MODULUS_EN
  localparam bit MOD_EN = 1'b1;
`else
  localparam bit MOD_EN = 1'b0;
`endif

  // Cycles one LCG step takes for a given operand width
  function automatic int unsigned step_lat(input int unsigned width);
    return MOD_EN ? (2 * width + 1) : 1;
  endfunction

  // LSB position of observation k inside the packed observation bus
  function automatic int unsigned obs_lsb(input int unsigned k, input int unsigned width);
    return k * width;
  endfunction

endpackage

// File: rtl/lcg_step.sv
// One LCG step lane: y = (a*x + c) mod M, reported with ready_c after step_lat cycles.
// Build option: LCG_MODULUS_EN selects a shift-subtract reduction by m; otherwise M = 2^WIDTH.
module lcg_step
  import lcg_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] m,
  output logic             ready_c,
  output logic [WIDTH-1:0] y_c
);

  localparam int unsigned PW = 2 * WIDTH;

`ifdef LCG_MODULUS_EN
  localparam int unsigned ITERS = step_lat(WIDTH) - 1;
  localparam int unsigned CW    = $clog2(ITERS + 1);

  logic [PW-1:0]    prod;
  logic [WIDTH-1:0] rem;
  logic [CW-1:0]    cnt;
  logic             run;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] nxt;

  // One restoring-reduction bit per cycle, MSB of the full sum first
  always_comb begin
    trial   = {rem, prod[PW-1]};
    nxt     = (trial >= {1'b0, m}) ? WIDTH'(trial - {1'b0, m}) : WIDTH'(trial);
    ready_c = run && (cnt == CW'(ITERS - 1));
    y_c     = nxt;
  end

  // Capture a*x+c on start, then walk it through the reducer
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      prod <= '0;
      rem  <= '0;
      cnt  <= '0;
      run  <= 1'b0;
    end else if (start) begin
      prod <= PW'(a) * PW'(x) + PW'(c);
      rem  <= '0;
      cnt  <= '0;
      run  <= 1'b1;
    end else if (run) begin
      prod <= {prod[PW-2:0], 1'b0};
      rem  <= nxt;
      cnt  <= cnt + CW'(1);
      if (cnt == CW'(ITERS - 1)) run <= 1'b0;
    end
  end
`else
  logic unused_ports;

  // Wrap mode: the result is the low half of the full-width sum
  always_comb begin
    ready_c = start;
    y_c     = WIDTH'(PW'(a) * PW'(x) + PW'(c));
  end

  assign unused_ports = ^{CLK, RST_N, m};
`endif

endmodule

// File: rtl/lcg_seed_scan.sv
// Brute-force LCG seed recovery over an inclusive seed range, LANES seeds per batch.
// Build option: LCG_MODULUS_EN enables the programmable modulus (default M = 2^WIDTH).
module lcg_seed_scan
  import lcg_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NUM_OBS = 3,
  parameter int unsigned LANES   = 4
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       start,
  input  logic                       abort,
  input  logic [WIDTH-1:0]           seed_lo,
  input  logic [WIDTH-1:0]           seed_hi,
  input  logic [WIDTH-1:0]           multiplier,
  input  logic [WIDTH-1:0]           increment,
  input  logic [WIDTH-1:0]           modulus,
  input  logic [NUM_OBS*WIDTH-1:0]   obs_data,
  output logic                       busy,
  output logic                       done,
  output logic                       found,
  output logic [WIDTH-1:0]           valid_seed,
  output logic [WIDTH:0]             seeds_tried
);

  localparam int unsigned OBW = NUM_OBS * WIDTH;
  localparam int unsigned KW  = (NUM_OBS > 1) ? $clog2(NUM_OBS) : 1;
  localparam int unsigned LW  = $clog2(LANES + 1);
  localparam int unsigned BW  = WIDTH + 2;

  state_t             state;
  logic [WIDTH-1:0]   lo_q, hi_q, a_q, c_q, m_q;
  logic [OBW-1:0]     obs_q;
  logic [WIDTH:0]     base;
  logic [KW-1:0]      k;
  logic               go;
  logic [LANES-1:0]   mask;
  logic [LANES-1:0]   kill;
  logic [WIDTH-1:0]   cur   [LANES];
  logic [WIDTH-1:0]   nxt_c [LANES];
  logic [LANES-1:0]   rdy_c;
  logic [WIDTH-1:0]   obs_arr [NUM_OBS];

  logic [WIDTH-1:0]   obs_k_c;
  logic [LANES-1:0]   live_c;
  logic               any_live_c;
  logic [WIDTH-1:0]   win_seed_c;
  logic [LW-1:0]      unmasked_c;
  logic               last_batch_c;
  logic               empty_c;
  logic               step_done_c;

  // Unpack the latched observation bus
  for (genvar g = 0; g < NUM_OBS; g++) begin : g_obs
    assign obs_arr[g] = obs_q[obs_lsb(g, WIDTH) +: WIDTH];
  end

  // Step lanes, all started together so they finish together
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    lcg_step #(.WIDTH(WIDTH)) u_step (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .start   (go),
      .x       (cur[g]),
      .a       (a_q),
      .c       (c_q),
      .m       (m_q),
      .ready_c (rdy_c[g]),
      .y_c     (nxt_c[g])
    );
  end

  // Batch bookkeeping: survivors, priority pick, unmasked count, range end
  always_comb begin
    obs_k_c     = obs_arr[k];
    step_done_c = &rdy_c;
    live_c      = ~kill & ~mask;
    any_live_c  = |live_c;
    win_seed_c  = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (live_c[i]) win_seed_c = WIDTH'(base + (WIDTH + 1)'(i));
    end
    unmasked_c = '0;
    for (int i = 0; i < LANES; i++) begin
      if (!mask[i]) unmasked_c = unmasked_c + LW'(1);
    end
    last_batch_c = ({1'b0, base} + BW'(LANES)) > BW'(hi_q);
`ifdef LCG_MODULUS_EN
    empty_c = (hi_q < lo_q) || (m_q == '0);
`else
    empty_c = (hi_q < lo_q);
`endif
  end

  // Scan FSM with registered handshake outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= S_IDLE;
      lo_q        <= '0;
      hi_q        <= '0;
      a_q         <= '0;
      c_q         <= '0;
      m_q         <= '0;
      obs_q       <= '0;
      base        <= '0;
      k           <= '0;
      go          <= 1'b0;
      mask        <= '0;
      kill        <= '0;
      for (int i = 0; i < LANES; i++) cur[i] <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      found       <= 1'b0;
      valid_seed  <= '0;
      seeds_tried <= '0;
    end else begin
      done <= 1'b0;
      go   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            lo_q        <= seed_lo;
            hi_q        <= seed_hi;
            a_q         <= multiplier;
            c_q         <= increment;
            m_q         <= modulus;
            obs_q       <= obs_data;
            base        <= {1'b0, seed_lo};
            busy        <= 1'b1;
            found       <= 1'b0;
            valid_seed  <= '0;
            seeds_tried <= '0;
            state       <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (abort || empty_c) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_FIN;
          end else begin
            for (int i = 0; i < LANES; i++) begin
              cur[i]  <= WIDTH'(base + (WIDTH + 1)'(i));
              mask[i] <= ({1'b0, base} + BW'(i)) > BW'(hi_q);
            end
            kill  <= '0;
            k     <= '0;
            go    <= 1'b1;
            state <= S_STEP;
          end
        end
        S_STEP: begin
          if (abort) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_FIN;
          end else if (step_done_c) begin
            for (int i = 0; i < LANES; i++) begin
              cur[i] <= nxt_c[i];
              if (nxt_c[i] != obs_k_c) kill[i] <= 1'b1;
            end
            if (k == KW'(NUM_OBS - 1)) begin
              state <= S_CHECK;
            end else begin
              k  <= k + KW'(1);
              go <= 1'b1;
            end
          end
        end
        S_CHECK: begin
          if (any_live_c) begin
            found      <= 1'b1;
            valid_seed <= win_seed_c;
            done       <= 1'b1;
            busy       <= 1'b0;
            state      <= S_FIN;
          end else begin
            seeds_tried <= seeds_tried + (WIDTH + 1)'(unmasked_c);
            if (abort || last_batch_c) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_FIN;
            end else begin
              base  <= base + (WIDTH + 1)'(LANES);
              state <= S_LOAD;
            end
          end
        end
        S_FIN: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcg_seed_scan.sv
// Self-checking bench for lcg_seed_scan: vector table, randomized scans against a
// plain-arithmetic seed search, plus abort / ignored-start / mid-scan reset sequences.
module tb_lcg_seed_scan;

  localparam int unsigned W  = 32;
  localparam int unsigned NO = 3;
  localparam int unsigned LN = 4;
`ifdef LCG_MODULUS_EN
  localparam bit          MODE = 1'b1;
  localparam int unsigned LAT  = 2 * W + 1;
`else
  localparam bit          MODE = 1'b0;
  localparam int unsigned LAT  = 1;
`endif
  localparam int unsigned BATCH = 2 + NO * LAT;

  logic            CLK = 1'b0;
  logic            RST_N = 1'b1;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic [W-1:0]    seed_lo = '0, seed_hi = '0, multiplier = '0, increment = '0, modulus = '0;
  logic [NO*W-1:0] obs_data = '0;
  logic            busy, done, found;
  logic [W-1:0]    valid_seed;
  logic [W:0]      seeds_tried;

  int checks = 0;
  int errors = 0;

  lcg_seed_scan #(.WIDTH(W), .NUM_OBS(NO), .LANES(LN)) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .start       (start),
    .abort       (abort),
    .seed_lo     (seed_lo),
    .seed_hi     (seed_hi),
    .multiplier  (multiplier),
    .increment   (increment),
    .modulus     (modulus),
    .obs_data    (obs_data),
    .busy        (busy),
    .done        (done),
    .found       (found),
    .valid_seed  (valid_seed),
    .seeds_tried (seeds_tried)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference LCG step on 64-bit integers
  function automatic logic [W-1:0] ref_step(input logic [W-1:0] a, c, m, x);
    logic [63:0] s;
    s = 64'(a) * 64'(x) + 64'(c);
    if (MODE) return W'(s % 64'(m));
    return W'(s);
  endfunction

  function automatic bit seed_ok(input logic [W-1:0] a, c, m, s, input logic [NO*W-1:0] obs);
    logic [W-1:0] v;
    v = s;
    for (int j = 0; j < NO; j++) begin
      v = ref_step(a, c, m, v);
      if (v != obs[j*W +: W]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic [NO*W-1:0] make_obs(input logic [W-1:0] a, c, m, s);
    logic [NO*W-1:0] o;
    logic [W-1:0] v;
    v = s;
    o = '0;
    for (int j = 0; j < NO; j++) begin
      v = ref_step(a, c, m, v);
      o[j*W +: W] = v;
    end
    return o;
  endfunction

  // Reference search: groups of LN seeds from lo, first group with a hit wins
  task automatic ref_scan(input logic [W-1:0] lo, hi, a, c, m, input logic [NO*W-1:0] obs,
                          output bit f, output logic [W-1:0] s, output longint tried,
                          output int lat);
    longint b, top, n;
    int hit;
    f = 1'b0; s = '0; tried = 0; lat = 1;
    if (hi < lo || (MODE && m == '0)) return;
    lat = 0;
    top = longint'(hi);
    for (b = longint'(lo); b <= top; b += LN) begin
      n = 0; hit = -1;
      lat += BATCH;
      for (int i = 0; i < LN; i++) begin
        if (b + i <= top) begin
          n++;
          if (hit < 0 && seed_ok(a, c, m, W'(b + i), obs)) hit = i;
        end
      end
      if (hit >= 0) begin
        f = 1'b1;
        s = W'(b + hit);
        return;
      end
      tried += n;
    end
  endtask

  // Start one scan, scramble inputs afterwards, wait for done and compare
  task automatic run_scan(input string tag, input logic [W-1:0] lo, hi, a, c, m,
                          input logic [NO*W-1:0] obs, input bit extra_starts,
                          input bit ef, input logic [W-1:0] es, input longint et);
    bit rf; logic [W-1:0] rs; longint rt; int elat; int cyc;
    ref_scan(lo, hi, a, c, m, obs, rf, rs, rt, elat);
    @(negedge CLK);
    seed_lo = lo; seed_hi = hi; multiplier = a; increment = c; modulus = m; obs_data = obs;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    seed_lo = $urandom; seed_hi = $urandom; multiplier = $urandom;
    increment = $urandom; modulus = $urandom; obs_data = {$urandom, $urandom, $urandom};
    check({tag, "_busy"}, 64'(busy), 64'(1));
    cyc = 0;
    while (done !== 1'b1 && cyc < elat + 20) begin
      start = extra_starts && (cyc % 5 == 2);
      if (extra_starts) begin seed_lo = 32'd10; seed_hi = 32'd5; end
      @(negedge CLK);
      cyc++;
    end
    start = 1'b0;
    check({tag, "_done_seen"}, 64'(done), 64'(1));
    check({tag, "_latency"}, 64'(cyc), 64'(elat));
    check({tag, "_found"}, 64'(found), 64'(ef));
    check({tag, "_seed"}, 64'(valid_seed), 64'(es));
    check({tag, "_tried"}, 64'(seeds_tried), 64'(et));
    check({tag, "_busy_end"}, 64'(busy), 64'(0));
    @(negedge CLK);
    check({tag, "_done_pulse"}, 64'(done), 64'(0));
    check({tag, "_found_held"}, 64'(found), 64'(ef));
  endtask

  typedef struct {
    string           name;
    logic [W-1:0]    lo, hi, a, c, m;
    logic [NO*W-1:0] obs;
    bit              ef;
    logic [W-1:0]    es;
    longint          et;
  } vec_t;

  vec_t tbl[6];

  initial begin
    bit rf; logic [W-1:0] rs; longint rt; int rl;
    logic [W-1:0] ra, rc, rm, rlo, rhi, tgt;
    logic [NO*W-1:0] robs;
    int cyc;

`ifdef LCG_MODULUS_EN
    tbl[0] = '{"t2_mod",    32'd0,  32'd200, 32'd4001, 32'd60211, 32'd993441,
               {32'd127141, 32'd466569, 32'd444307}, 1'b1, 32'd96, 96};
    tbl[1] = '{"t3a_none",  32'd0,  32'd95,  32'd1, 32'd0, 32'd1000, {3{32'd500}}, 1'b0, 32'd0, 96};
    tbl[2] = '{"t3b_single",32'd97, 32'd97,  32'd1, 32'd0, 32'd1000, {3{32'd500}}, 1'b0, 32'd0, 1};
    tbl[3] = '{"t4_lowest", 32'd97, 32'd200, 32'd0, 32'd5, 32'd1000, {3{32'd5}},   1'b1, 32'd97, 0};
    tbl[4] = '{"t5_empty",  32'd10, 32'd5,   32'd1, 32'd0, 32'd1000, {3{32'd7}},   1'b0, 32'd0, 0};
    tbl[5] = '{"m_zero",    32'd0,  32'd10,  32'd1, 32'd0, 32'd0,    {3{32'd7}},   1'b0, 32'd0, 0};
`else
    tbl[0] = '{"t1_wrap",   32'd0,  32'd200, 32'd4001, 32'd60211, 32'd0,
               {32'd242022553, 32'd1777732518, 32'd444307}, 1'b1, 32'd96, 96};
    tbl[1] = '{"t3a_none",  32'd0,  32'd95,  32'd4001, 32'd60211, 32'd0,
               {32'd242022553, 32'd1777732518, 32'd444307}, 1'b0, 32'd0, 96};
    tbl[2] = '{"t3b_single",32'd97, 32'd97,  32'd4001, 32'd60211, 32'd0,
               {32'd242022553, 32'd1777732518, 32'd444307}, 1'b0, 32'd0, 1};
    tbl[3] = '{"t4_lowest", 32'd97, 32'd200, 32'd0, 32'd5, 32'd0, {3{32'd5}}, 1'b1, 32'd97, 0};
    tbl[4] = '{"top_none",  32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, {3{32'd5}},
               1'b0, 32'd0, 3};
    tbl[5] = '{"top_hit",   32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0, 32'd5, 32'd0, {3{32'd5}},
               1'b1, 32'hFFFF_FFFE, 0};
`endif

    // Reset state
    #1 RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_busy",  64'(busy), 64'(0));
    check("rst_done",  64'(done), 64'(0));
    check("rst_found", 64'(found), 64'(0));
    check("rst_seed",  64'(valid_seed), 64'(0));
    check("rst_tried", 64'(seeds_tried), 64'(0));
    RST_N = 1'b1;

    // Vector table
    for (int t = 0; t < 6; t++) begin
      run_scan(tbl[t].name, tbl[t].lo, tbl[t].hi, tbl[t].a, tbl[t].c, tbl[t].m, tbl[t].obs,
               1'b0, tbl[t].ef, tbl[t].es, tbl[t].et);
    end

    // Empty range and start pulses while busy
    run_scan("empty", 32'd10, 32'd5, 32'd1, 32'd0, 32'd1000, {3{32'd7}}, 1'b0, 1'b0, 32'd0, 0);
    run_scan("seq_seed7", 32'd0, 32'd10, 32'd1, 32'd0, 32'd1000, {3{32'd7}}, 1'b1,
             1'b1, 32'd7, 4);

    // Randomized scans against the reference search
    for (int r = 0; r < 20; r++) begin
      rm  = MODE ? W'($urandom_range(2000, 1 << 20)) : '0;
      ra  = $urandom;
      rc  = $urandom;
      if (MODE) begin ra = ra % rm; rc = rc % rm; end
      rlo = W'($urandom_range(0, 1000));
      rhi = (r % 7 == 6) ? rlo - 32'd1 : rlo + W'($urandom_range(0, 40));
      tgt = rlo + W'($urandom_range(0, 50));
      robs = (r % 5 == 4) ? {$urandom, $urandom, $urandom} : make_obs(ra, rc, rm, tgt);
      if (MODE && r % 5 == 4) robs = {3{W'(1)}};
      ref_scan(rlo, rhi, ra, rc, rm, robs, rf, rs, rt, rl);
      run_scan($sformatf("rand%0d", r), rlo, rhi, ra, rc, rm, robs, 1'b0, rf, rs, rt);
    end

    // Abort in the third batch: two full batches counted
    @(negedge CLK);
    seed_lo = 32'd0; seed_hi = 32'd1000; multiplier = 32'd1; increment = 32'd0;
    modulus = 32'd100000; obs_data = {3{32'd5000}};
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    cyc = 0;
    while (cyc < 2 * BATCH + 1) begin
      @(negedge CLK);
      cyc++;
    end
    abort = 1'b1;
    @(negedge CLK);
    abort = 1'b0;
    check("abort_done",  64'(done), 64'(1));
    check("abort_found", 64'(found), 64'(0));
    check("abort_busy",  64'(busy), 64'(0));
    check("abort_tried", 64'(seeds_tried), 64'(8));
    @(negedge CLK);
    check("abort_done_pulse", 64'(done), 64'(0));

    // Reset in the middle of a scan
    seed_lo = 32'd0; seed_hi = 32'd1000; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (3 * BATCH) @(negedge CLK);
    check("midrst_pre_busy", 64'(busy), 64'(1));
    #2 RST_N = 1'b0;
    #1;
    check("midrst_busy",  64'(busy), 64'(0));
    check("midrst_done",  64'(done), 64'(0));
    check("midrst_found", 64'(found), 64'(0));
    check("midrst_seed",  64'(valid_seed), 64'(0));
    check("midrst_tried", 64'(seeds_tried), 64'(0));
    @(negedge CLK);
    RST_N = 1'b1;
    run_scan("post_rst", 32'd97, 32'd200, 32'd0, 32'd5, 32'd1000, {3{32'd5}}, 1'b0,
             1'b1, 32'd97, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
